// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one line-level main-memory interface between the
// instruction cache (i_*) and the data cache (d_*). One whole-line
// transaction at a time. Simultaneous requests alternate between the caches.
// A watchdog ends a transaction that memory never acknowledges.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   i_mem_* / d_mem_*     cache request side: enable, op, address, write line, op_done
//   i_/d_mem_data_ready   response valid to the cache
//   i_/d_mem_data_out     response line to the cache
//   i_/d_memory_in_use    memory busy indication (mirrors busy)
//   mem_enable/op/address/data_in   request to memory, driven from the latches
//   mem_data_ready/data_out         memory completion and read line
//   grant_d               current or last owner (1 dcache, 0 icache)
//   busy                  a transaction is in progress
//   timeout_error         sticky watchdog flag, cleared only by reset
module memory_arbiter #(
  parameter int unsigned MEMORY_ADDRESS_SIZE = 32,
  parameter int unsigned CACHE_LINE_SIZE     = 128,
  parameter int unsigned TIMEOUT_CYCLES      = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_mem_enable,
  input  logic                           i_mem_op,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] i_mem_address,
  input  logic [CACHE_LINE_SIZE-1:0]     i_mem_data_in,
  input  logic                           i_mem_op_done,
  output logic                           i_mem_data_ready,
  output logic [CACHE_LINE_SIZE-1:0]     i_mem_data_out,
  output logic                           i_memory_in_use,
  input  logic                           d_mem_enable,
  input  logic                           d_mem_op,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] d_mem_address,
  input  logic [CACHE_LINE_SIZE-1:0]     d_mem_data_in,
  input  logic                           d_mem_op_done,
  output logic                           d_mem_data_ready,
  output logic [CACHE_LINE_SIZE-1:0]     d_mem_data_out,
  output logic                           d_memory_in_use,
  output logic                           mem_enable,
  output logic                           mem_op,
  output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
  output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
  input  logic                           mem_data_ready,
  input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
  output logic                           grant_d,
  output logic                           busy,
  output logic                           timeout_error
);

  // Watchdog counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_RESPOND  = 2'd2;

  logic [1:0]                     r_state,         w_state;
  logic                           r_last_grant,    w_last_grant;
  logic                           r_grant_d,       w_grant_d;
  logic [CNT_W-1:0]               r_counter,       w_counter;
  logic                           r_timeout_error, w_timeout_error;
  logic                           r_mem_enable,    w_mem_enable;
  logic                           r_mem_op,        w_mem_op;
  logic [MEMORY_ADDRESS_SIZE-1:0] r_mem_address,   w_mem_address;
  logic [CACHE_LINE_SIZE-1:0]     r_mem_data_in,   w_mem_data_in;
  logic                           r_i_ready,       w_i_ready;
  logic                           r_d_ready,       w_d_ready;
  logic [CACHE_LINE_SIZE-1:0]     r_i_dout,        w_i_dout;
  logic [CACHE_LINE_SIZE-1:0]     r_d_dout,        w_d_dout;
  logic                           r_busy,          w_busy;
  logic                           w_pick_d;
  logic                           w_done;

  // Next-state and next-output logic.
  always_comb begin
    w_state         = r_state;
    w_last_grant    = r_last_grant;
    w_grant_d       = r_grant_d;
    w_counter       = r_counter;
    w_timeout_error = r_timeout_error;
    w_mem_enable    = r_mem_enable;
    w_mem_op        = r_mem_op;
    w_mem_address   = r_mem_address;
    w_mem_data_in   = r_mem_data_in;
    w_i_ready       = r_i_ready;
    w_d_ready       = r_d_ready;
    w_i_dout        = r_i_dout;
    w_d_dout        = r_d_dout;
    // On a tie the port that was not served last wins.
    w_pick_d        = d_mem_enable && (!i_mem_enable || !r_last_grant);
    w_done          = r_grant_d ? (d_mem_op_done || !d_mem_enable)
                                : (i_mem_op_done || !i_mem_enable);

    case (r_state)
      S_IDLE: begin
        if (i_mem_enable || d_mem_enable) begin
          w_grant_d     = w_pick_d;
          w_mem_op      = w_pick_d ? d_mem_op      : i_mem_op;
          w_mem_address = w_pick_d ? d_mem_address : i_mem_address;
          w_mem_data_in = w_pick_d ? d_mem_data_in : i_mem_data_in;
          w_counter     = '0;
          w_mem_enable  = 1'b1;
          w_state       = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (mem_data_ready) begin
          w_i_ready    = !r_grant_d;
          w_d_ready    = r_grant_d;
          w_i_dout     = r_grant_d ? '0 : mem_data_out;
          w_d_dout     = r_grant_d ? mem_data_out : '0;
          w_mem_enable = 1'b0;
          w_state      = S_RESPOND;
        end else if (r_counter == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog: answer the owner with an all-zero line.
          w_timeout_error = 1'b1;
          w_i_ready       = !r_grant_d;
          w_d_ready       = r_grant_d;
          w_i_dout        = '0;
          w_d_dout        = '0;
          w_mem_enable    = 1'b0;
          w_state         = S_RESPOND;
        end else begin
          w_counter = r_counter + CNT_W'(1);
        end
      end
      S_RESPOND: begin
        if (w_done) begin
          w_i_ready    = 1'b0;
          w_d_ready    = 1'b0;
          w_i_dout     = '0;
          w_d_dout     = '0;
          w_last_grant = r_grant_d;
          w_state      = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_last_grant    <= 1'b0;
      r_grant_d       <= 1'b0;
      r_counter       <= '0;
      r_timeout_error <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_mem_op        <= 1'b0;
      r_mem_address   <= '0;
      r_mem_data_in   <= '0;
      r_i_ready       <= 1'b0;
      r_d_ready       <= 1'b0;
      r_i_dout        <= '0;
      r_d_dout        <= '0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_last_grant    <= w_last_grant;
      r_grant_d       <= w_grant_d;
      r_counter       <= w_counter;
      r_timeout_error <= w_timeout_error;
      r_mem_enable    <= w_mem_enable;
      r_mem_op        <= w_mem_op;
      r_mem_address   <= w_mem_address;
      r_mem_data_in   <= w_mem_data_in;
      r_i_ready       <= w_i_ready;
      r_d_ready       <= w_d_ready;
      r_i_dout        <= w_i_dout;
      r_d_dout        <= w_d_dout;
      r_busy          <= w_busy;
    end
  end

  assign i_mem_data_ready = r_i_ready;
  assign i_mem_data_out   = r_i_dout;
  assign i_memory_in_use  = r_busy;
  assign d_mem_data_ready = r_d_ready;
  assign d_mem_data_out   = r_d_dout;
  assign d_memory_in_use  = r_busy;
  assign mem_enable       = r_mem_enable;
  assign mem_op           = r_mem_op;
  assign mem_address      = r_mem_address;
  assign mem_data_in      = r_mem_data_in;
  assign grant_d          = r_grant_d;
  assign busy             = r_busy;
  assign timeout_error    = r_timeout_error;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized bench for memory_arbiter.
// Keeps a transaction-level model of both caches and of memory: pending
// requests per port, the port served last, and the sticky watchdog flag.
module tb_memory_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 128;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_mem_enable, i_mem_op, i_mem_op_done;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_data_in;
  logic          i_mem_data_ready, i_memory_in_use;
  logic [LW-1:0] i_mem_data_out;
  logic          d_mem_enable, d_mem_op, d_mem_op_done;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_data_in;
  logic          d_mem_data_ready, d_memory_in_use;
  logic [LW-1:0] d_mem_data_out;
  logic          mem_enable, mem_op, mem_data_ready;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in, mem_data_out;
  logic          grant_d, busy, timeout_error;

  memory_arbiter #(
    .MEMORY_ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_mem_enable(i_mem_enable), .i_mem_op(i_mem_op), .i_mem_address(i_mem_address),
    .i_mem_data_in(i_mem_data_in), .i_mem_op_done(i_mem_op_done),
    .i_mem_data_ready(i_mem_data_ready), .i_mem_data_out(i_mem_data_out),
    .i_memory_in_use(i_memory_in_use),
    .d_mem_enable(d_mem_enable), .d_mem_op(d_mem_op), .d_mem_address(d_mem_address),
    .d_mem_data_in(d_mem_data_in), .d_mem_op_done(d_mem_op_done),
    .d_mem_data_ready(d_mem_data_ready), .d_mem_data_out(d_mem_data_out),
    .d_memory_in_use(d_memory_in_use),
    .mem_enable(mem_enable), .mem_op(mem_op), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_ready(mem_data_ready),
    .mem_data_out(mem_data_out),
    .grant_d(grant_d), .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: index 0 = icache, 1 = dcache.
  logic          pend[2];
  logic          req_op[2];
  logic [AW-1:0] req_addr[2];
  logic [LW-1:0] req_data[2];
  logic          drv_en[2], drv_op[2], drv_done[2];
  logic [AW-1:0] drv_addr[2];
  logic [LW-1:0] drv_data[2];
  int            last_port;
  logic          tmo_exp;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply();
    i_mem_enable  = drv_en[0];   d_mem_enable  = drv_en[1];
    i_mem_op      = drv_op[0];   d_mem_op      = drv_op[1];
    i_mem_address = drv_addr[0]; d_mem_address = drv_addr[1];
    i_mem_data_in = drv_data[0]; d_mem_data_in = drv_data[1];
    i_mem_op_done = drv_done[0]; d_mem_op_done = drv_done[1];
  endtask

  task automatic new_req(input int p, input logic op, input logic [AW-1:0] addr,
                         input logic [LW-1:0] data);
    pend[p] = 1'b1; req_op[p] = op; req_addr[p] = addr; req_data[p] = data;
    drv_en[p] = 1'b1; drv_op[p] = op; drv_addr[p] = addr; drv_data[p] = data;
    drv_done[p] = 1'b0;
  endtask

  // One full transaction: grant, memory phase, response, release.
  task automatic serve(input int lat, input bit never, input bit drop, input bit inject,
                       input int hold, input logic [LW-1:0] rdata);
    int            w, o, hi;
    logic          w_op;
    logic [AW-1:0] w_addr;
    logic [LW-1:0] w_data, exp_line;
    logic [LW-1:0] got_w, got_o;
    if (pend[0] && pend[1]) w = 1 - last_port;
    else if (pend[1])       w = 1;
    else                    w = 0;
    o = 1 - w;
    w_op = req_op[w]; w_addr = req_addr[w]; w_data = req_data[w];
    apply();
    @(negedge clk);
    check_eq("grant_mem_enable", LW'(mem_enable), LW'(1));
    check_eq("grant_owner", LW'(grant_d), LW'(w));
    check_eq("grant_in_use", LW'({d_memory_in_use, i_memory_in_use, busy}), LW'(3'b111));
    check_eq("grant_op", LW'(mem_op), LW'(w_op));
    check_eq("grant_addr", LW'(mem_address), LW'(w_addr));
    check_eq("grant_wdata", mem_data_in, w_data);
    // Winner inputs become don't-care once latched.
    drv_op[w] = 1'($urandom_range(0, 1)); drv_addr[w] = $urandom; drv_data[w] = rand_line();
    if (drop) begin drv_en[w] = 1'b0; pend[w] = 1'b0; end
    if (inject && !pend[o]) new_req(o, 1'($urandom_range(0, 1)), $urandom, rand_line());
    hi = 1;
    for (int c = 1; c <= int'(2 * TMO + 8); c++) begin
      mem_data_ready = (!never && c > lat);
      mem_data_out   = rdata;
      apply();
      @(negedge clk);
      if (!mem_enable) break;
      hi++;
      check_eq("wait_op", LW'(mem_op), LW'(w_op));
      check_eq("wait_addr", LW'(mem_address), LW'(w_addr));
      check_eq("wait_wdata", mem_data_in, w_data);
      check_eq("wait_no_ready", LW'({d_mem_data_ready, i_mem_data_ready}), LW'(0));
    end
    mem_data_ready = 1'b0;
    mem_data_out   = rand_line();
    exp_line = never ? '0 : rdata;
    if (never) tmo_exp = 1'b1;
    check_eq("mem_enable_cycles", LW'(hi), never ? LW'(TMO) : LW'(lat + 1));
    for (int h = 0; h <= (drop ? 0 : hold); h++) begin
      got_w = w ? d_mem_data_out : i_mem_data_out;
      got_o = w ? i_mem_data_out : d_mem_data_out;
      check_eq("resp_ready", LW'({d_mem_data_ready, i_mem_data_ready}), LW'(w ? 2'b10 : 2'b01));
      check_eq("resp_data", got_w, exp_line);
      check_eq("resp_other_data", got_o, LW'(0));
      check_eq("resp_busy", LW'({busy, mem_enable}), LW'(2'b10));
      check_eq("resp_timeout_flag", LW'(timeout_error), LW'(tmo_exp));
      if (!drop && h < hold) begin
        // Stray memory completions during RESPOND must be ignored.
        mem_data_ready = 1'b1; mem_data_out = rand_line();
        apply();
        @(negedge clk);
      end
    end
    if (!drop) drv_done[w] = 1'b1;
    mem_data_ready = 1'b0;
    apply();
    @(negedge clk);
    drv_done[w] = 1'b0; drv_en[w] = 1'b0; pend[w] = 1'b0;
    apply();
    last_port = w;
    check_eq("idle_busy", LW'({busy, d_memory_in_use, i_memory_in_use, mem_enable}), LW'(0));
    check_eq("idle_ready", LW'({d_mem_data_ready, i_mem_data_ready}), LW'(0));
    check_eq("idle_data", i_mem_data_out | d_mem_data_out, LW'(0));
    check_eq("idle_owner", LW'(grant_d), LW'(w));
  endtask

  initial begin
    int k;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; req_op[p] = 1'b0; req_addr[p] = '0; req_data[p] = '0;
      drv_en[p] = 1'b0; drv_op[p] = 1'b0; drv_done[p] = 1'b0;
      drv_addr[p] = '0; drv_data[p] = '0;
    end
    reset = 1'b0; mem_data_ready = 1'b0; mem_data_out = '0;
    last_port = 0; tmo_exp = 1'b0;
    apply();

    // Reset held with both caches requesting.
    new_req(0, 1'b0, 32'h0000_1000, rand_line());
    new_req(1, 1'b0, 32'h0000_2000, rand_line());
    apply();
    repeat (2) @(negedge clk);
    check_eq("rst_mem_side", LW'({mem_enable, mem_op, mem_address}), LW'(0));
    check_eq("rst_mem_wdata", mem_data_in, LW'(0));
    check_eq("rst_flags", LW'({busy, grant_d, timeout_error, i_memory_in_use, d_memory_in_use}), LW'(0));
    check_eq("rst_ready", LW'({d_mem_data_ready, i_mem_data_ready}), LW'(0));
    check_eq("rst_data", i_mem_data_out | d_mem_data_out, LW'(0));
    reset = 1'b1;
    serve(2, 1'b0, 1'b0, 1'b0, 0, rand_line());   // dcache first
    serve(1, 1'b0, 1'b0, 1'b0, 0, rand_line());   // then icache

    // icache read, memory ready three cycles after mem_enable.
    new_req(0, 1'b0, 32'h0000_0040, rand_line());
    serve(3, 1'b0, 1'b0, 1'b0, 1, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Simultaneous requests twice in a row.
    repeat (2) begin
      new_req(0, 1'b0, $urandom, rand_line());
      new_req(1, 1'b1, $urandom, rand_line());
      serve(1, 1'b0, 1'b0, 1'b0, 0, rand_line());
      serve(0, 1'b0, 1'b0, 1'b0, 0, rand_line());
    end

    // dcache write with an icache request arriving mid-write.
    new_req(1, 1'b1, 32'h0000_0100, 128'hAAAAAAAAAAAAAAAA5555555555555555);
    serve(3, 1'b0, 1'b0, 1'b1, 0, rand_line());
    serve(2, 1'b0, 1'b0, 1'b0, 0, rand_line());

    // Watchdog, then a normal transaction with the flag still set.
    new_req(1, 1'b0, 32'h0000_0300, rand_line());
    serve(0, 1'b1, 1'b0, 1'b0, 0, rand_line());
    new_req(0, 1'b0, 32'h0000_0340, rand_line());
    serve(2, 1'b0, 1'b0, 1'b0, 0, rand_line());

    // Requester abandons during WAIT_MEM.
    new_req(0, 1'b1, 32'h0000_0380, rand_line());
    serve(3, 1'b0, 1'b1, 1'b0, 0, rand_line());

    // One-cycle reset in the middle of WAIT_MEM.
    new_req(0, 1'b0, 32'h0000_0200, rand_line());
    apply();
    @(negedge clk);
    check_eq("prerst_mem_enable", LW'(mem_enable), LW'(1));
    reset = 1'b0; drv_en[0] = 1'b0; pend[0] = 1'b0;
    apply();
    @(negedge clk);
    reset = 1'b1; last_port = 0; tmo_exp = 1'b0;
    check_eq("midrst_state", LW'({mem_enable, busy, grant_d, timeout_error}), LW'(0));
    check_eq("midrst_ready", LW'({d_mem_data_ready, i_mem_data_ready}), LW'(0));
    @(negedge clk);
    check_eq("postrst_ready", LW'({d_mem_data_ready, i_mem_data_ready, busy}), LW'(0));
    new_req(0, 1'b0, 32'h0000_0240, rand_line());
    serve(2, 1'b0, 1'b0, 1'b0, 0, rand_line());

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if (!pend[0] && !pend[1]) begin
        k = $urandom_range(1, 3);
        if ((k & 1) != 0) new_req(0, 1'($urandom_range(0, 1)), $urandom, rand_line());
        if ((k & 2) != 0) new_req(1, 1'($urandom_range(0, 1)), $urandom, rand_line());
      end
      serve($urandom_range(0, 4), ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 2), rand_line());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-port arbiter that shares the single main-memory line interface between the instruction cache (port i) and the data cache (port d).
- Sits between both cache instances and the memory module, and presents each cache the same line-level handshake the cache already speaks (mem_enable/mem_op/mem_address/mem_data_in out; mem_data_ready/mem_data_out/memory_in_use in).
- Serialises whole-line transactions with round-robin fairness and a watchdog on memory latency.

Parameters:
MEMORY_ADDRESS_SIZE, 32, memory address width
CACHE_LINE_SIZE, 128, line width in bits
TIMEOUT_CYCLES, 64, max cycles mem_enable may stay high without mem_data_ready (>=2)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets the block)
i_mem_enable  in  1  icache request valid
i_mem_op  in  1  icache op: 0 read, 1 write
i_mem_address  in  MEMORY_ADDRESS_SIZE  icache line address
i_mem_data_in  in  CACHE_LINE_SIZE  icache write line
i_mem_op_done  in  1  icache consumed response
i_mem_data_ready  out  1  response valid to icache
i_mem_data_out  out  CACHE_LINE_SIZE  read line to icache
i_memory_in_use  out  1  memory busy indication to icache
d_mem_enable, d_mem_op, d_mem_address, d_mem_data_in, d_mem_op_done  in  (same widths)  dcache request side
d_mem_data_ready, d_mem_data_out, d_memory_in_use  out  (same widths)  dcache response side
mem_enable  out  1  request to memory
mem_op  out  1  0 read, 1 write
mem_address  out  MEMORY_ADDRESS_SIZE  latched address
mem_data_in  out  CACHE_LINE_SIZE  latched write line
mem_data_ready  in  1  memory finished
mem_data_out  in  CACHE_LINE_SIZE  memory read line
grant_d  out  1  current/last owner: 1 dcache, 0 icache
busy  out  1  state != IDLE
timeout_error  out  1  sticky watchdog flag

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, last_grant=icache, grant_d=0, counter=0, timeout_error=0.
  - All out ports 0, including data buses and the response register.
  - Reset overrides any in-flight transaction; no completion is reported for it.
- States: IDLE, WAIT_MEM, RESPOND.
- IDLE:
  - No enable: stay in IDLE.
  - One enable: grant that port.
  - Both enables: grant the port not in last_grant (first tie after reset goes to dcache).
  - On grant: latch op/address/data of the winner, set grant_d, counter=0, next state WAIT_MEM.
- WAIT_MEM:
  - mem_enable=1 and mem_op/mem_address/mem_data_in driven from the latches, stable for the whole state. Requester inputs are ignored after latching.
  - On mem_data_ready=1: capture mem_data_out into the response register, mem_enable=0 next cycle, go to RESPOND.
  - Otherwise counter++. When counter==TIMEOUT_CYCLES-1 without ready: set timeout_error=1, response register=0, mem_enable=0, go to RESPOND.
- RESPOND:
  - Granted port sees x_mem_data_ready=1 and x_mem_data_out=response register. The other port sees data_ready=0 and data_out=0.
  - Exit to IDLE when granted x_mem_op_done==1 or x_mem_enable==0. On exit, last_grant=granted port.
  - Write transactions also pass through RESPOND; data_out content is don't-care for writes but must be deterministic (captured value).
- x_memory_in_use = busy, for both ports.
- Latency: enable sampled at edge N (IDLE) -> mem_enable=1 from N+1. Memory ready sampled at edge M -> x_mem_data_ready=1 from M+1. Minimum turnaround is one IDLE cycle between transactions.
- Boundary conditions:
  - Requester drops enable during WAIT_MEM: memory transaction still completes (no torn writes), then RESPOND exits on the next edge.
  - Non-granted requests during busy: held by the requester, never lost or reordered, served at the next IDLE.
  - mem_data_ready outside WAIT_MEM: ignored.
  - timeout_error: cleared only by reset.
  - Counter width: clog2(TIMEOUT_CYCLES); must not wrap before the timeout fires.

Test Plan:
1. Hold reset=0 for 2 cycles with both enables high -> all outputs 0, busy=0; with reset=1, dcache granted first (grant_d=1).
2. icache read, address 0x00000040, memory ready 3 cycles after mem_enable with 0x0123...CDEF -> mem_op=0 and mem_address=0x40 throughout; i_mem_data_ready=1 with that line one cycle after ready; d_memory_in_use=1 throughout; idle after i_mem_op_done.
3. Both request simultaneously twice in a row -> order is d, i, then d, i; each exactly one transaction; losing request fields unchanged.
4. dcache write, address 0x00000100, line 0xAAAA...5555 -> mem_op=1, mem_data_in equals the line, d_mem_data_ready after memory ready; icache request issued mid-write is served only after return to IDLE.
5. TIMEOUT_CYCLES=8, memory never ready -> mem_enable high exactly 8 cycles, timeout_error=1, d_mem_data_ready=1 with data 0; the next request still completes normally and timeout_error stays 1.
6. reset=0 for one cycle during WAIT_MEM -> next cycle mem_enable=0, busy=0, no data_ready pulse; a subsequent icache read completes with correct data.
